// File: rtl/issue_scoreboard.sv
// In-order multi-issue hazard scoreboard: a per-register countdown until the in-flight
// result is forwardable, and each cycle a grant for the longest hazard-free in-order prefix.
module issue_scoreboard #(
    parameter int ISSUE_WIDTH    = 2,
    parameter int NUM_REGS       = 128,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int LAT_WIDTH      = 3,
    parameter int NUM_PIPES      = 2,
    parameter int PIPE_ID_WIDTH  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [ISSUE_WIDTH-1:0]                  in_valid,
    input  logic [ISSUE_WIDTH*3*REG_ADDR_WIDTH-1:0] in_src_addr,
    input  logic [ISSUE_WIDTH*3-1:0]                in_src_used,
    input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0]   in_rt,
    input  logic [ISSUE_WIDTH-1:0]                  in_wr_en,
    input  logic [ISSUE_WIDTH*LAT_WIDTH-1:0]        in_lat,
    input  logic [ISSUE_WIDTH*PIPE_ID_WIDTH-1:0]    in_pipe,
    input  logic                                    flush,
    output logic [ISSUE_WIDTH-1:0]                  out_issue,
    output logic                                    out_stall,
    output logic                                    out_pending,
    output logic [31:0]                             stall_cycles
);
    // Handshake: in_valid[i] offers slot i and out_issue[i] is its ready. A slot is consumed
    // only in a cycle where both are high; ungranted slots are re-offered unchanged upstream.

    logic [LAT_WIDTH-1:0]      pend_cnt_q [NUM_REGS];
    logic [LAT_WIDTH-1:0]      pend_cnt_d [NUM_REGS];
    logic [31:0]               stall_cycles_q;
    logic [31:0]               stall_cycles_d;

    logic [NUM_REGS-1:0]       older_wr_mask;
    logic [NUM_PIPES-1:0]      older_pipe_mask;
    logic [REG_ADDR_WIDTH-1:0] src_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [LAT_WIDTH-1:0]      lat_val;
    logic [PIPE_ID_WIDTH-1:0]  pipe_id;
    logic                      slot_ok;
    logic                      grant_chain;

    // Older slots are accumulated into masks whether granted or not, so a younger slot
    // never overtakes a dependency on an instruction still waiting in the same group.
    always_comb begin
        older_wr_mask   = '0;
        older_pipe_mask = '0;
        src_addr        = '0;
        rt_addr         = '0;
        lat_val         = '0;
        pipe_id         = '0;
        slot_ok         = 1'b0;
        out_issue       = '0;
        grant_chain     = !flush && !reset;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rt_addr = in_rt[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            lat_val = in_lat[i*LAT_WIDTH +: LAT_WIDTH];
            pipe_id = in_pipe[i*PIPE_ID_WIDTH +: PIPE_ID_WIDTH];
            slot_ok = in_valid[i];
            for (int k = 0; k < 3; k++) begin
                src_addr = in_src_addr[(i*3+k)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                if (in_src_used[i*3+k] &&
                    ((pend_cnt_q[src_addr] != '0) || older_wr_mask[src_addr])) begin
                    slot_ok = 1'b0;
                end
            end
            if (in_wr_en[i] && ((pend_cnt_q[rt_addr] > lat_val) || older_wr_mask[rt_addr])) begin
                slot_ok = 1'b0;
            end
            if (older_pipe_mask[pipe_id]) begin
                slot_ok = 1'b0;
            end
            grant_chain  = grant_chain && slot_ok;
            out_issue[i] = grant_chain;
            if (in_valid[i]) begin
                older_pipe_mask[pipe_id] = 1'b1;
                if (in_wr_en[i]) begin
                    older_wr_mask[rt_addr] = 1'b1;
                end
            end
        end
    end

    // A newly issued writer overrides the decrement of its destination counter.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_cnt_d[r] = (pend_cnt_q[r] != '0) ? pend_cnt_q[r] - LAT_WIDTH'(1) : pend_cnt_q[r];
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (out_issue[i] && in_wr_en[i]) begin
                pend_cnt_d[in_rt[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = in_lat[i*LAT_WIDTH +: LAT_WIDTH];
            end
        end
    end

    always_comb begin
        out_pending = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            out_pending = out_pending | (|pend_cnt_q[r]);
        end
    end

    assign out_stall      = !reset && (|(in_valid & ~out_issue));
    assign stall_cycles_d = out_stall ? stall_cycles_q + 32'd1 : stall_cycles_q;
    assign stall_cycles   = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_cnt_q[r] <= pend_cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard in a 4-wide, 4-pipe build: directed hazard scenarios then
// random traffic, checked against a ready-time model of the register file.
module tb_issue_scoreboard;
    localparam int IW  = 4;
    localparam int NR  = 128;
    localparam int RAW = 7;
    localparam int LW  = 3;
    localparam int NP  = 4;
    localparam int PW  = 2;
    localparam int EW  = IW + 34;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0]       in_valid = '0;
    logic [IW*3*RAW-1:0] in_src_addr = '0;
    logic [IW*3-1:0]     in_src_used = '0;
    logic [IW*RAW-1:0]   in_rt = '0;
    logic [IW-1:0]       in_wr_en = '0;
    logic [IW*LW-1:0]    in_lat = '0;
    logic [IW*PW-1:0]    in_pipe = '0;
    logic                flush = 1'b0;
    logic [IW-1:0]       out_issue;
    logic                out_stall;
    logic                out_pending;
    logic [31:0]         stall_cycles;

    issue_scoreboard #(
        .ISSUE_WIDTH(IW), .NUM_REGS(NR), .REG_ADDR_WIDTH(RAW),
        .LAT_WIDTH(LW), .NUM_PIPES(NP), .PIPE_ID_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_src_addr(in_src_addr),
        .in_src_used(in_src_used), .in_rt(in_rt), .in_wr_en(in_wr_en), .in_lat(in_lat),
        .in_pipe(in_pipe), .flush(flush), .out_issue(out_issue), .out_stall(out_stall),
        .out_pending(out_pending), .stall_cycles(stall_cycles)
    );

    // slot stimulus
    logic s_valid [IW];
    int   s_src   [IW][3];
    logic s_used  [IW][3];
    int   s_rt    [IW];
    logic s_wr    [IW];
    int   s_lat   [IW];
    int   s_pipe  [IW];

    // reference model: cycle at which each register becomes readable
    int ready_at [NR];
    int now = 0;
    int stall_cnt = 0;
    logic [IW-1:0] last_grant;

    // scoreboard
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int checks = 0;
    int errors = 0;

    function automatic int pend(input int r);
        return (ready_at[r] > now) ? ready_at[r] - now : 0;
    endfunction

    task automatic clear_slots();
        for (int i = 0; i < IW; i++) begin
            s_valid[i] = 1'b0; s_rt[i] = 0; s_wr[i] = 1'b0; s_lat[i] = 1; s_pipe[i] = 0;
            for (int k = 0; k < 3; k++) begin
                s_src[i][k] = 0; s_used[i][k] = 1'b0;
            end
        end
    endtask

    task automatic set_w(input int i, input int rt, input int lat, input int pipe);
        s_valid[i] = 1'b1; s_wr[i] = 1'b1; s_rt[i] = rt; s_lat[i] = lat; s_pipe[i] = pipe;
    endtask

    task automatic set_r(input int i, input int src, input int pipe);
        s_valid[i] = 1'b1; s_wr[i] = 1'b0; s_pipe[i] = pipe;
        s_src[i][0] = src; s_used[i][0] = 1'b1;
    endtask

    // driver: apply one cycle of stimulus and push the model's expected response
    task automatic step(input logic fl, input logic rst);
        logic [IW-1:0] g;
        logic chain, ok, stl, pnd;
        @(posedge clk);
        #1;
        for (int i = 0; i < IW; i++) begin
            in_valid[i] = s_valid[i];
            in_wr_en[i] = s_wr[i];
            in_rt[i*RAW +: RAW]  = RAW'(s_rt[i]);
            in_lat[i*LW +: LW]   = LW'(s_lat[i]);
            in_pipe[i*PW +: PW]  = PW'(s_pipe[i]);
            for (int k = 0; k < 3; k++) begin
                in_src_addr[(i*3+k)*RAW +: RAW] = RAW'(s_src[i][k]);
                in_src_used[i*3+k] = s_used[i][k];
            end
            if (s_valid[i] && s_wr[i]) assert (s_lat[i] != 0);
        end
        flush = fl;
        reset = rst;
        chain = !fl && !rst;
        for (int i = 0; i < IW; i++) begin
            ok = s_valid[i];
            for (int k = 0; k < 3; k++)
                if (s_used[i][k] && pend(s_src[i][k]) != 0) ok = 1'b0;
            if (s_wr[i] && pend(s_rt[i]) > s_lat[i]) ok = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (s_valid[j]) begin
                    if (s_pipe[j] == s_pipe[i]) ok = 1'b0;
                    if (s_wr[j] && s_wr[i] && s_rt[j] == s_rt[i]) ok = 1'b0;
                    for (int k = 0; k < 3; k++)
                        if (s_wr[j] && s_used[i][k] && s_src[i][k] == s_rt[j]) ok = 1'b0;
                end
            end
            chain = chain && ok;
            g[i] = chain;
        end
        stl = 1'b0;
        for (int i = 0; i < IW; i++) if (s_valid[i] && !g[i]) stl = 1'b1;
        if (rst) stl = 1'b0;
        pnd = 1'b0;
        for (int r = 0; r < NR; r++) if (pend(r) != 0) pnd = 1'b1;
        exp_q.push_back({g, stl, pnd, 32'(stall_cnt)});
        if (rst) begin
            for (int r = 0; r < NR; r++) ready_at[r] = 0;
            stall_cnt = 0;
        end else begin
            for (int i = 0; i < IW; i++)
                if (g[i] && s_wr[i]) ready_at[s_rt[i]] = now + 1 + s_lat[i];
            if (stl) stall_cnt++;
        end
        now++;
        last_grant = g;
    endtask

    task automatic offer_until(input int slot, input int max_cycles);
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
        end while (!last_grant[slot] && n < max_cycles);
    endtask

    task automatic drain(input int n);
        clear_slots();
        repeat (n) step(1'b0, 1'b0);
    endtask

    // monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (out_issue !== e[34 +: IW]) begin
                errors++;
                $display("FAIL issue t=%0t got=%b exp=%b", $time, out_issue, e[34 +: IW]);
            end
            if (out_stall !== e[33]) begin
                errors++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time, out_stall, e[33]);
            end
            if (out_pending !== e[32]) begin
                errors++;
                $display("FAIL pending t=%0t got=%b exp=%b", $time, out_pending, e[32]);
            end
            if (stall_cycles !== e[31:0]) begin
                errors++;
                $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, stall_cycles, e[31:0]);
            end
        end
    end

    initial begin
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        clear_slots();
        repeat (2) @(posedge clk);

        step(1'b0, 1'b0);                                  // reset state, idle
        set_w(0, 5, 2, 0); set_w(1, 6, 4, 1); step(1'b0, 1'b0);  // independent pair
        drain(6);

        set_w(0, 10, 6, 0); step(1'b0, 1'b0);              // cross-cycle RAW
        clear_slots(); set_r(0, 10, 0); offer_until(0, 20);
        drain(2);

        set_w(0, 3, 1, 0); set_r(1, 3, 1); step(1'b0, 1'b0);    // intra-group RAW
        drain(3);
        set_w(0, 30, 1, 0); set_w(1, 31, 1, 0); step(1'b0, 1'b0); // same pipe
        drain(3);
        set_w(1, 32, 1, 1); step(1'b0, 1'b0);              // slot0 invalid
        drain(3);

        set_w(0, 7, 5, 0); step(1'b0, 1'b0);               // WAW with count 5
        clear_slots(); set_w(0, 7, 2, 0); offer_until(0, 20);
        drain(8);

        set_w(0, 40, 5, 0); step(1'b0, 1'b0);              // flush with pending counters
        clear_slots(); set_w(0, 41, 1, 0); set_w(1, 42, 1, 1);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        drain(6);

        set_w(0, 50, 7, 0); set_w(1, 51, 7, 1); step(1'b0, 1'b0);  // reset mid-drain
        clear_slots(); set_r(0, 50, 0);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
        drain(2);

        set_w(0, 60, 2, 0); set_w(1, 61, 2, 1); set_w(2, 62, 2, 2); set_w(3, 63, 2, 3);
        step(1'b0, 1'b0);                                  // four-wide independent
        drain(3);
        set_w(0, 70, 2, 0); set_w(1, 71, 2, 1); set_r(2, 70, 2); set_w(3, 73, 2, 3);
        step(1'b0, 1'b0);                                  // slot2 depends on slot0
        drain(4);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < IW; i++) begin
                s_valid[i] = ($urandom_range(0, 3) != 0);
                s_rt[i]    = $urandom_range(0, 15);
                s_wr[i]    = $urandom_range(0, 1);
                s_lat[i]   = s_wr[i] ? $urandom_range(1, 7) : $urandom_range(0, 7);
                s_pipe[i]  = $urandom_range(0, NP - 1);
                for (int k = 0; k < 3; k++) begin
                    s_src[i][k]  = $urandom_range(0, 15);
                    s_used[i][k] = ($urandom_range(0, 2) == 0);
                end
            end
            step($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
        end
        drain(2);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
